seg7_scan_to_bcd: RTL
=====================

// Module: seg7_scan_to_bcd
// PURPOSE
//  Receive side of the 7-segment display interface: turns segment codes back into BCD.
//  Watches a multiplexed 4-digit 7-segment bus (segment pattern + one-hot digit select).
//  Decodes each stable digit back to BCD and assembles one 4-digit frame.
//  Delivers the frame over a valid/ready handshake. Used for display loopback checks.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples required to accept a digit (legal range 2..255)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  seg        in   7   segment pattern {a,b,c,d,e,f,g}, active-high
//  dig_sel    in   4   one-hot digit select; bit i = digit i (digit 3 = most significant)
//  out_valid  out  1   frame available
//  out_ready  in   1   consumer accepts the frame
//  out_bcd    out  16  {d3,d2,d1,d0}, 4 bits per digit
//  out_err    out  4   per-digit flag: pattern was not a legal code
//  out_blank  out  4   per-digit flag: pattern was 7'h00
//  out_ovr    out  1   at least one frame was dropped before this frame
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0. Internal state cleared: counter, seen-mask, FSM=SETTLE.
//  Decode table, seg to BCD:
//   7E->0  30->1  6D->2  79->3  33->4  5B->5  5F->6  70->7  7F->8  7B->9
//   00->F with blank=1, err=0
//   any other code->F with err=1, blank=0
//  Sampling:
//   {seg,dig_sel} is registered once per clock.
//   A sample that differs from the previous one restarts the counter at 1.
//   Each identical sample increments the counter, saturating at STABLE_CYCLES.
//  FSM SETTLE:
//   Counter reaches STABLE_CYCLES and dig_sel is one-hot -> issue one accept pulse, go to LOCKED.
//   dig_sel not one-hot (zero or multiple bits set) -> nothing is accepted; stay in SETTLE.
//  FSM LOCKED:
//   Held until the sample changes; a change goes back to SETTLE with counter=1.
//   Holding a pattern longer never produces a second accept.
//  Latency: if the pair is constant on the bus from edge k, accept occurs at edge k+STABLE_CYCLES.
//  Accept action:
//   Writes decoded digit, err and blank into slot i and sets seen[i].
//   Re-accepting an already-seen slot overwrites it; the last value wins.
//  Frame completion (seen==4'hF after an accept), evaluated on the next edge:
//   Output register empty, or being emptied this cycle (out_valid&out_ready):
//    load out_bcd/out_err/out_blank.
//    out_ovr = pending_ovr; clear pending_ovr.
//    out_valid=1; clear seen.
//   Output register full and not being taken: drop the frame, set pending_ovr=1, clear seen.
//  Handshake:
//   out_valid stays high and all out_* stay stable until out_valid&out_ready is seen at a clock edge.
//   The cycle after that handshake, out_valid=0 unless a new frame loads in the same edge.
//   out_ready is ignored while out_valid=0.
//  Mid-operation reset: a partial frame is discarded, and any pending output is lost.
// TESTING
//  T1: scan 7E,30,6D,79 on sel 8,4,2,1; hold each 6 cycles; ready=1
//      -> one valid frame: bcd=16'h0123, err=0, blank=0, ovr=0.
//  T2: STABLE_CYCLES=4; hold a pattern 3 cycles, then change it
//      -> no accept; a hold of exactly 4 cycles -> accept at edge k+4.
//  T3: digit 2 driven 7'h49, digit 0 driven 7'h00; others legal
//      -> err=4'b0100, blank=4'b0001, those nibbles read F.
//  T4: ready=0 across two complete frames (1234 then 5678); then ready=1
//      -> first frame 1234 delivered with ovr=0, 5678 dropped.
//      A third frame 9012 is then delivered with ovr=1.
//  T5: dig_sel=4'b0110 held 10 cycles -> no accept, seen unchanged.
//  T6: assert rst_n=0 after 2 digits accepted; release and scan a full frame
//      -> all outputs 0 during reset; only the new frame is delivered.

Source files
------------

// File: rtl/seg7_scan_to_bcd_if.sv
// Bundle for the multiplexed 7-segment bus and the decoded-frame handshake.
// The slave side is the receiver (decoder). The master side drives the bus and consumes the frames.
interface seg7_scan_to_bcd_if;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic [3:0]  out_blank;
  logic        out_ovr;

  modport slave (
    input  seg, dig_sel, out_ready,
    output out_valid, out_bcd, out_err, out_blank, out_ovr
  );

  modport master (
    output seg, dig_sel, out_ready,
    input  out_valid, out_bcd, out_err, out_blank, out_ovr
  );
endinterface

// File: rtl/seg7_scan_to_bcd.sv
// Loopback receiver for a scanned 4-digit 7-segment display.
// It waits for each {segment, select} pair to stay stable, then decodes it back to BCD.
// When all four digit slots are filled, it delivers one frame over a valid/ready handshake.
module seg7_scan_to_bcd #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_to_bcd_if.slave  bus
);
  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] STABLE     = 8'(STABLE_CYCLES);

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                         state, state_nxt;
  logic [10:0]                    din, smp;
  logic                           changed;
  logic [7:0]                     cnt;
  logic                           accept;
  logic [NUM_DIGITS-1:0]          wr;
  logic [5:0]                     dec;
  logic [NUM_DIGITS-1:0][3:0]     slot_bcd;
  logic [NUM_DIGITS-1:0]          slot_err, slot_blank, seen;
  logic                           valid_q, ovr_q, pend_ovr;
  logic [15:0]                    bcd_q;
  logic [3:0]                     err_q, blank_q;

  // Decoded digit packed as {blank, err, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = {2'b00, 4'd0};
      7'h30:   decode = {2'b00, 4'd1};
      7'h6D:   decode = {2'b00, 4'd2};
      7'h79:   decode = {2'b00, 4'd3};
      7'h33:   decode = {2'b00, 4'd4};
      7'h5B:   decode = {2'b00, 4'd5};
      7'h5F:   decode = {2'b00, 4'd6};
      7'h70:   decode = {2'b00, 4'd7};
      7'h7F:   decode = {2'b00, 4'd8};
      7'h7B:   decode = {2'b00, 4'd9};
      7'h00:   decode = {2'b10, 4'hF};
      default: decode = {2'b01, 4'hF};
    endcase
  endfunction

  assign din     = {bus.seg, bus.dig_sel};
  assign changed = (din != smp);
  assign dec     = decode(smp[10:4]);

  // Bus sample register plus a saturating run-length counter of identical samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
      cnt <= '0;
    end else begin
      smp <= din;
      if (changed)          cnt <= 8'd1;
      else if (cnt < STABLE) cnt <= cnt + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  // Next state: any bus change re-arms the FSM. A single accept locks it until the next change.
  always_comb begin
    state_nxt = state;
    if (changed)     state_nxt = SETTLE;
    else if (accept) state_nxt = LOCKED;
  end

  // FSM outputs: one accept pulse per stable one-hot pair, steered to its digit slot.
  always_comb begin
    accept = (state == SETTLE) && (cnt == STABLE) && $onehot(smp[3:0]);
    wr     = accept ? smp[3:0] : '0;
  end

  // Digit slots. Re-accepting a slot overwrites it, so the last value wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_bcd   <= '0;
      slot_err   <= '0;
      slot_blank <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr[i]) begin
          slot_bcd[i]   <= dec[3:0];
          slot_err[i]   <= dec[4];
          slot_blank[i] <= dec[5];
        end
      end
    end
  end

  // Frame assembly and output register.
  // A full frame either loads into the output or is dropped and flagged for the next delivered frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen     <= '0;
      valid_q  <= 1'b0;
      bcd_q    <= '0;
      err_q    <= '0;
      blank_q  <= '0;
      ovr_q    <= 1'b0;
      pend_ovr <= 1'b0;
    end else if (&seen) begin
      seen <= wr;
      if (!valid_q || bus.out_ready) begin
        valid_q  <= 1'b1;
        bcd_q    <= slot_bcd;
        err_q    <= slot_err;
        blank_q  <= slot_blank;
        ovr_q    <= pend_ovr;
        pend_ovr <= 1'b0;
      end else begin
        pend_ovr <= 1'b1;
      end
    end else begin
      seen <= seen | wr;
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.out_err   = err_q;
  assign bus.out_blank = blank_q;
  assign bus.out_ovr   = ovr_q;
endmodule
